// File: rtl/tqv_periph_hub.sv
`default_nettype none
// ============================================================================
//  Module   : tqv_periph_hub
//  Brief    : TinyQV peripheral interconnect. Decodes the peripheral address
//             into slots and gates strobes to the selected slot. Owns a
//             register slot for GPIO, pin function select, interrupt mask and
//             sticky error status. Reads go through a handshake FSM with a
//             timeout. Interrupts are masked and registered.
//  Revision : 1.0 - initial release
// ============================================================================
module tqv_periph_hub #(
  parameter int NUM_PERI       = 16,
  parameter int NUM_PINS       = 8,
  parameter int HUB_SLOT       = 1,
  parameter int UART_SLOT      = 2,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_PINS-1:0]          ui_in,
  output logic [NUM_PINS-1:0]          uo_out,
  input  logic [10:0]                  addr_in,
  input  logic [31:0]                  data_in,
  input  logic [1:0]                   data_write_n,
  input  logic [1:0]                   data_read_n,
  output logic [31:0]                  data_out,
  output logic                         data_ready,
  input  logic                         data_read_complete,
  output logic [5:0]                   peri_address,
  output logic [31:0]                  peri_data_in,
  output logic [2*NUM_PERI-1:0]        peri_write_n,
  output logic [2*NUM_PERI-1:0]        peri_read_n,
  input  logic [32*NUM_PERI-1:0]       peri_data_out,
  input  logic [NUM_PERI-1:0]          peri_data_ready,
  input  logic [NUM_PINS*NUM_PERI-1:0] peri_uo,
  input  logic [NUM_PERI-1:0]          peri_irq,
  output logic [NUM_PERI-1:0]          user_interrupts
);

  localparam int SEL_W = (NUM_PERI > 1) ? $clog2(NUM_PERI) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]       c_hub_slot   = 5'(HUB_SLOT);
  localparam logic [5:0]       c_off_gpio   = 6'h00;
  localparam logic [5:0]       c_off_ui     = 6'h04;
  localparam logic [5:0]       c_off_status = 6'h08;
  localparam logic [5:0]       c_off_mask   = 6'h0C;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                    r_state, w_state_next;
  logic [CNT_W-1:0]          r_cnt;
  logic [4:0]                r_wait_slot;
  logic [31:0]               r_data_out;
  logic [NUM_PINS-1:0]       r_gpio;
  logic [NUM_PERI-1:0]       r_irq_mask;
  logic [NUM_PERI-1:0]       r_user_irq;
  logic                      r_st_to, r_st_unm;
  logic [4:0]                r_st_slot;
  logic [NUM_PINS*SEL_W-1:0] w_sel_flat;

  logic [4:0]  w_slot;
  logic [5:0]  w_off;
  logic        w_is_hub, w_is_mapped, w_is_ext, w_rd_req, w_wr_req, w_hub_wr;
  logic        w_rd_phase;
  logic [31:0] w_peri_rdata, w_wait_rdata, w_hub_rdata, w_cap_data;
  logic        w_peri_ready, w_wait_ready;
  logic        w_cap_en, w_cnt_clr, w_cnt_inc, w_wait_ld, w_rd_to, w_rd_unm;
  logic        w_set_unm, w_st_w1c;

  assign w_slot      = addr_in[10:6];
  assign w_off       = addr_in[5:0];
  assign w_is_hub    = (w_slot == c_hub_slot);
  assign w_is_mapped = ({27'd0, w_slot} < 32'(NUM_PERI));
  assign w_is_ext    = w_is_mapped && !w_is_hub;
  assign w_rd_req    = (data_read_n != 2'b11);
  assign w_wr_req    = (data_write_n != 2'b11);
  assign w_hub_wr    = w_wr_req && w_is_hub;
  assign w_rd_phase  = (r_state == S_IDLE) || (r_state == S_WAIT);

  assign peri_address    = addr_in[5:0];
  assign peri_data_in    = data_in;
  assign data_out        = r_data_out;
  assign data_ready      = (r_state == S_HOLD) || w_wr_req;
  assign user_interrupts = r_user_irq;

  // The hub slot's pin drive is replaced by gpio_out and never looked at.
  logic w_unused;
  assign w_unused = &{1'b0, peri_uo[HUB_SLOT*NUM_PINS +: NUM_PINS]};

  // Per-slot strobe gating; the hub pair stays idle since w_is_ext excludes it.
  for (genvar s = 0; s < NUM_PERI; s++) begin : g_strobe
    logic w_sel;
    assign w_sel = !reset && w_is_ext && (w_slot == 5'(s));
    assign peri_write_n[2*s +: 2] = w_sel ? data_write_n : 2'b11;
    assign peri_read_n[2*s +: 2]  = (w_sel && w_rd_phase) ? data_read_n : 2'b11;
  end

  // Read data / ready of the addressed slot and of the slot being waited on.
  always_comb begin
    w_peri_rdata = '0;
    w_peri_ready = 1'b0;
    w_wait_rdata = '0;
    w_wait_ready = 1'b0;
    for (int s = 0; s < NUM_PERI; s++) begin
      if (w_slot == 5'(s)) begin
        w_peri_rdata = peri_data_out[32*s +: 32];
        w_peri_ready = peri_data_ready[s];
      end
      if (r_wait_slot == 5'(s)) begin
        w_wait_rdata = peri_data_out[32*s +: 32];
        w_wait_ready = peri_data_ready[s];
      end
    end
  end

  // Hub register read mux; unknown offsets read as zero.
  always_comb begin
    w_hub_rdata = '0;
    case (w_off)
      c_off_gpio:   w_hub_rdata[NUM_PINS-1:0] = r_gpio;
      c_off_ui:     w_hub_rdata[NUM_PINS-1:0] = ui_in;
      c_off_status: w_hub_rdata = {19'd0, r_st_slot, 6'd0, r_st_unm, r_st_to};
      c_off_mask:   w_hub_rdata[NUM_PERI-1:0] = r_irq_mask;
      default:      w_hub_rdata = '0;
    endcase
    for (int k = 0; k < NUM_PINS; k++) begin
      if (w_off == 6'(32 + 4*k)) w_hub_rdata[SEL_W-1:0] = w_sel_flat[k*SEL_W +: SEL_W];
    end
  end

  // Read handshake FSM: next state, capture and error flags.
  always_comb begin
    w_state_next = r_state;
    w_cap_en     = 1'b0;
    w_cap_data   = '0;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    w_wait_ld    = 1'b0;
    w_rd_to      = 1'b0;
    w_rd_unm     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rd_req) begin
          if (w_is_hub) begin
            w_cap_en = 1'b1; w_cap_data = w_hub_rdata; w_state_next = S_HOLD;
          end else if (!w_is_mapped) begin
            w_cap_en = 1'b1; w_rd_unm = 1'b1; w_state_next = S_HOLD;
          end else if (w_peri_ready) begin
            w_cap_en = 1'b1; w_cap_data = w_peri_rdata; w_state_next = S_HOLD;
          end else begin
            w_cnt_clr = 1'b1; w_wait_ld = 1'b1; w_state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!w_rd_req) begin
          w_state_next = S_IDLE;
        end else if (w_wait_ready) begin
          w_cap_en = 1'b1; w_cap_data = w_wait_rdata; w_state_next = S_HOLD;
        end else if (r_cnt == c_cnt_last) begin
          w_cap_en = 1'b1; w_cap_data = 32'hFFFF_FFFF; w_rd_to = 1'b1;
          w_state_next = S_HOLD;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_HOLD: begin
        if (data_read_complete || !w_rd_req) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM state, wait counter, waited slot and captured read data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_wait_slot <= '0;
      r_data_out  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
      if (w_wait_ld)      r_wait_slot <= w_slot;
      if (w_cap_en)       r_data_out  <= w_cap_data;
    end
  end

  assign w_set_unm = w_rd_unm || (w_wr_req && !w_is_mapped);
  assign w_st_w1c  = w_hub_wr && (w_off == c_off_status);

  // GPIO, mask and sticky status; a new error beats a same-cycle clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_gpio     <= '0;
      r_irq_mask <= '0;
      r_st_to    <= 1'b0;
      r_st_unm   <= 1'b0;
      r_st_slot  <= '0;
    end else begin
      if (w_hub_wr && (w_off == c_off_gpio)) r_gpio     <= data_in[NUM_PINS-1:0];
      if (w_hub_wr && (w_off == c_off_mask)) r_irq_mask <= data_in[NUM_PERI-1:0];
      r_st_to  <= (r_st_to  && !(w_st_w1c && data_in[0])) || w_rd_to;
      r_st_unm <= (r_st_unm && !(w_st_w1c && data_in[1])) || w_set_unm;
      if (w_rd_to)        r_st_slot <= r_wait_slot;
      else if (w_set_unm) r_st_slot <= w_slot;
    end
  end

  // Masked interrupts, one cycle behind the request lines.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_user_irq <= '0;
    else       r_user_irq <= peri_irq & r_irq_mask;
  end

  // Per-pin function select register and output mux.
  for (genvar k = 0; k < NUM_PINS; k++) begin : g_pin
    localparam logic [SEL_W-1:0] c_sel_rst = (k < 2) ? SEL_W'(UART_SLOT) : SEL_W'(HUB_SLOT);
    logic [SEL_W-1:0] r_sel;
    logic             w_pin;

    // Function select for this pin.
    always_ff @(posedge clock or posedge reset) begin
      if (reset)                                      r_sel <= c_sel_rst;
      else if (w_hub_wr && (w_off == 6'(32 + 4*k)))   r_sel <= data_in[SEL_W-1:0];
    end

    // Pick the pin driver; codes with no slot behind them drive 0.
    always_comb begin
      w_pin = 1'b0;
      for (int s = 0; s < NUM_PERI; s++) begin
        if (r_sel == SEL_W'(s)) w_pin = (s == HUB_SLOT) ? r_gpio[k] : peri_uo[s*NUM_PINS + k];
      end
    end

    assign uo_out[k] = w_pin;
    assign w_sel_flat[k*SEL_W +: SEL_W] = r_sel;
  end

endmodule
`default_nettype wire

// File: tb/tb_tqv_periph_hub.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tqv_periph_hub
//  Brief    : Directed self-checking bench for tqv_periph_hub.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tqv_periph_hub;

  logic          clock = 1'b0;
  logic          reset;
  logic [7:0]    ui_in;
  logic [7:0]    uo_out;
  logic [10:0]   addr_in;
  logic [31:0]   data_in;
  logic [1:0]    data_write_n;
  logic [1:0]    data_read_n;
  logic [31:0]   data_out;
  logic          data_ready;
  logic          data_read_complete;
  logic [5:0]    peri_address;
  logic [31:0]   peri_data_in;
  logic [31:0]   peri_write_n;
  logic [31:0]   peri_read_n;
  logic [511:0]  peri_data_out;
  logic [15:0]   peri_data_ready;
  logic [127:0]  peri_uo;
  logic [15:0]   peri_irq;
  logic [15:0]   user_interrupts;

  int n_checks = 0;
  int n_errors = 0;

  tqv_periph_hub dut (
    .clock              (clock),
    .reset              (reset),
    .ui_in              (ui_in),
    .uo_out             (uo_out),
    .addr_in            (addr_in),
    .data_in            (data_in),
    .data_write_n       (data_write_n),
    .data_read_n        (data_read_n),
    .data_out           (data_out),
    .data_ready         (data_ready),
    .data_read_complete (data_read_complete),
    .peri_address       (peri_address),
    .peri_data_in       (peri_data_in),
    .peri_write_n       (peri_write_n),
    .peri_read_n        (peri_read_n),
    .peri_data_out      (peri_data_out),
    .peri_data_ready    (peri_data_ready),
    .peri_uo            (peri_uo),
    .peri_irq           (peri_irq),
    .user_interrupts    (user_interrupts)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Hub write: ready is combinational and the hub pair never strobes.
  task automatic wr(input logic [10:0] a, input logic [31:0] d);
    addr_in = a; data_in = d; data_write_n = 2'b10;
    #1;
    check("wr_rdy", {31'd0, data_ready}, 32'd1);
    check("hub_wstb", peri_write_n, 32'hFFFF_FFFF);
    tick();
    data_write_n = 2'b11;
  endtask

  // Read with a bounded wait; n is the number of edges until data_ready.
  task automatic rd(input logic [10:0] a, output logic [31:0] d, output int n);
    addr_in = a; data_read_n = 2'b10; n = 0;
    do begin
      tick();
      n++;
    end while (!data_ready && n < 40);
    d = data_out;
    data_read_n = 2'b11;
    tick();
  endtask

  initial begin
    logic [31:0] d;
    int          n;

    reset = 1'b1; ui_in = 8'h3C; addr_in = '0; data_in = '0;
    data_write_n = 2'b11; data_read_n = 2'b11; data_read_complete = 1'b0;
    peri_data_out = '0; peri_data_ready = '0; peri_irq = '0; peri_uo = '0;
    peri_data_out[32*5 +: 32] = 32'h1234_5678;
    peri_data_out[32*6 +: 32] = 32'hDEAD_BEEF;
    peri_uo[8*1 +: 8] = 8'hFF;   // hub slot drive, must be ignored
    peri_uo[8*2 +: 8] = 8'h02;
    peri_uo[8*4 +: 8] = 8'h08;

    #3;
    check("rst_ready", {31'd0, data_ready}, 32'd0);
    check("rst_dout", data_out, 32'd0);
    check("rst_irq", {16'd0, user_interrupts}, 32'd0);
    check("rst_uo", {24'd0, uo_out}, 32'h02);
    #9 reset = 1'b0;
    tick();

    // broadcast address/data
    addr_in = 11'h2AB; data_in = 32'hCAFE_F00D; #1;
    check("peri_addr", {26'd0, peri_address}, 32'h2B);
    check("peri_din", peri_data_in, 32'hCAFE_F00D);

    // hub status read after reset
    rd(11'h048, d, n);
    check("st_lat", n, 1);
    check("st_rst", d, 32'd0);

    // GPIO and function select
    wr(11'h040, 32'hA5);
    wr(11'h07C, 32'd1);   // func_sel[7] = hub
    wr(11'h06C, 32'd4);   // func_sel[3] = slot 4
    check("uo7", {31'd0, uo_out[7]}, 32'd1);
    check("uo_mux", {24'd0, uo_out}, 32'hAE);
    rd(11'h040, d, n);  check("gpio_rd", d, 32'h0000_00A5);
    rd(11'h06C, d, n);  check("fsel3_rd", d, 32'd4);
    rd(11'h044, d, n);  check("ui_rd", d, 32'h3C);
    rd(11'h050, d, n);  check("hole_rd", d, 32'd0);

    // external write to slot 3
    addr_in = 11'h0C0; data_write_n = 2'b01; #1;
    check("ext_wstb", peri_write_n, 32'hFFFF_FF7F);
    check("ext_wrdy", {31'd0, data_ready}, 32'd1);
    tick(); data_write_n = 2'b11;

    // slot 5, ready after 3 wait cycles
    addr_in = 11'h140; data_read_n = 2'b10; #1;
    check("s5_rstb", peri_read_n, 32'hFFFF_FBFF);
    n = 0;
    repeat (3) begin
      tick(); n++;
      check("s5_wait", {31'd0, data_ready}, 32'd0);
      check("s5_rstb_w", peri_read_n, 32'hFFFF_FBFF);
    end
    peri_data_ready[5] = 1'b1;
    tick(); n++;
    check("s5_lat", {31'd0, data_ready}, 32'd1);
    check("s5_cyc", n, 4);
    check("s5_data", data_out, 32'h1234_5678);
    check("s5_hold_stb", peri_read_n, 32'hFFFF_FFFF);
    peri_data_ready[5] = 1'b0; data_read_complete = 1'b1;
    tick(); data_read_complete = 1'b0;
    check("s5_done", {31'd0, data_ready}, 32'd0);
    data_read_n = 2'b11; tick();

    // slot 6 timeout
    rd(11'h180, d, n);
    check("to_cyc", n, 16);
    check("to_data", d, 32'hFFFF_FFFF);
    rd(11'h048, d, n);  check("to_status", d, 32'h0000_0601);
    wr(11'h048, 32'h1);
    rd(11'h048, d, n);  check("to_w1c", d, 32'h0000_0600);

    // timeout set coincides with W1C of the same bit: set wins
    addr_in = 11'h180; data_read_n = 2'b10;
    repeat (15) tick();
    check("to2_pend", {31'd0, data_ready}, 32'd0);
    addr_in = 11'h048; data_in = 32'h1; data_write_n = 2'b10;
    tick();
    check("to2_data", data_out, 32'hFFFF_FFFF);
    data_write_n = 2'b11; data_read_n = 2'b11;
    tick();
    rd(11'h048, d, n);  check("set_wins", d, 32'h0000_0601);
    wr(11'h048, 32'h1);

    // unmapped slot 20
    rd(11'h500, d, n);
    check("unm_lat", n, 1);
    check("unm_data", d, 32'd0);
    rd(11'h048, d, n);  check("unm_status", d, 32'h0000_1402);
    wr(11'h048, 32'h2);
    rd(11'h048, d, n);  check("unm_w1c", d, 32'h0000_1400);
    addr_in = 11'h440; data_write_n = 2'b10; #1;
    check("unm_wstb", peri_write_n, 32'hFFFF_FFFF);
    tick(); data_write_n = 2'b11;
    rd(11'h048, d, n);  check("unm_wr_st", d, 32'h0000_1102);

    // interrupts
    peri_irq = 16'h0006;
    wr(11'h04C, 32'h4);
    check("irq_pre", {16'd0, user_interrupts}, 32'd0);
    tick();
    check("irq_mask", {16'd0, user_interrupts}, 32'h0004);

    // reset in WAIT
    addr_in = 11'h1C0; data_read_n = 2'b10;
    tick();
    check("s7_wstb", peri_read_n, 32'hFFFF_BFFF);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_rdy", {31'd0, data_ready}, 32'd0);
    check("rst_mid_irq", {16'd0, user_interrupts}, 32'd0);
    check("rst_mid_stb", peri_read_n, 32'hFFFF_FFFF);
    data_read_n = 2'b11;
    #2 reset = 1'b0;
    tick();
    rd(11'h040, d, n);  check("rst_gpio", d, 32'd0);
    check("rst_uo2", {24'd0, uo_out}, 32'h02);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
